// File: rtl/pll_rst_seq.sv
// pll_rst_seq: qualifies the PLL lock and sequences the active-low system reset, clocked from the board oscillator.
// Optional macro PLL_RST_SEQ_TIMEOUT_EN adds a WAIT_LOCK timeout that pulses pll_rst_o and counts retries.
module pll_rst_seq #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned RST_HOLD_CYC     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 250000,
  parameter int unsigned PLL_RST_CYC      = 64,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             extlock_i,
  output logic             sys_rst_n_o,
  output logic             ready_o,
  output logic             pll_rst_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [CNT_W-1:0] retry_cnt_o
);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_STABLE    = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_LOST      = 3'd4;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam logic [2:0] S_PLL_RST   = 3'd5;
`endif

  // The single cycle counter must reach the largest terminal count of any state.
  localparam int unsigned MAX_SH  = (LOCK_STABLE_CYC > RST_HOLD_CYC) ? LOCK_STABLE_CYC : RST_HOLD_CYC;
  localparam int unsigned MAX_TP  = (LOCK_TIMEOUT_CYC > PLL_RST_CYC) ? LOCK_TIMEOUT_CYC : PLL_RST_CYC;
  localparam int unsigned CYC_MAX = (MAX_SH > MAX_TP) ? MAX_SH : MAX_TP;
  localparam int unsigned CYC_W   = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic [CYC_W-1:0]       cyc_q;
  logic [CYC_W-1:0]       cyc_d;
  logic                   sys_rst_n_d;
  logic [CNT_W-1:0]       loss_d;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
  logic                   pll_rst_d;
  logic [CNT_W-1:0]       retry_d;
`endif

  // Lock synchroniser; the only consumer of extlock_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], extlock_i};
    end
  end

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign state_o = state_q;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        else if (cyc_q == CYC_W'(LOCK_TIMEOUT_CYC - 1)) begin
          state_d = S_PLL_RST;
        end
`endif
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cyc_q == CYC_W'(LOCK_STABLE_CYC - 1)) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cyc_q == CYC_W'(RST_HOLD_CYC - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_LOST;
        end
      end
      S_LOST: begin
        state_d = S_WAIT_LOCK;
      end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
      S_PLL_RST: begin
        if (cyc_q == CYC_W'(PLL_RST_CYC - 1)) begin
          state_d = S_WAIT_LOCK;
        end
      end
`endif
      default: begin
        state_d = S_WAIT_LOCK;
      end
    endcase

    cyc_d       = (state_d != state_q) ? '0 : cyc_q + CYC_W'(1);
    sys_rst_n_d = (state_d == S_RUN);

    loss_d = loss_cnt_o;
    if ((state_d == S_LOST) && (loss_cnt_o != CNT_SAT)) begin
      loss_d = loss_cnt_o + CNT_W'(1);
    end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    pll_rst_d = (state_d == S_PLL_RST);
    retry_d   = retry_cnt_o;
    if ((state_d == S_PLL_RST) && (state_q != S_PLL_RST) && (retry_cnt_o != CNT_SAT)) begin
      retry_d = retry_cnt_o + CNT_W'(1);
    end
`endif
  end

  // State, cycle counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT_LOCK;
      cyc_q       <= '0;
      sys_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
      loss_cnt_o  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      sys_rst_n_o <= sys_rst_n_d;
      ready_o     <= sys_rst_n_d;
      loss_cnt_o  <= loss_d;
    end
  end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_o   <= 1'b0;
      retry_cnt_o <= '0;
    end else begin
      pll_rst_o   <= pll_rst_d;
      retry_cnt_o <= retry_d;
    end
  end
`else
  assign pll_rst_o   = 1'b0;
  assign retry_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: a run-length lock model predicts every cycle, a monitor compares.
`timescale 1ns/1ps
module tb_pll_rst_seq;
  localparam int unsigned SYNC = 2;
  localparam int unsigned STAB = 8;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 100;
  localparam int unsigned PRC  = 5;
  localparam int unsigned CW   = 8;
  localparam int FULL = 1 + STAB + HOLD;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          extlock;
  logic          sys_rst_n_o, ready_o, pll_rst_o;
  logic [2:0]    state_o;
  logic [CW-1:0] loss_cnt_o, retry_cnt_o;

  pll_rst_seq #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYC(STAB), .RST_HOLD_CYC(HOLD),
    .LOCK_TIMEOUT_CYC(TMO), .PLL_RST_CYC(PRC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .extlock_i(extlock),
    .sys_rst_n_o(sys_rst_n_o), .ready_o(ready_o), .pll_rst_o(pll_rst_o),
    .state_o(state_o), .loss_cnt_o(loss_cnt_o), .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int srn; int rdy; int pll; int loss; int retry; int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  bit   pipe [SYNC];
  int   run, in_pll, wait_cyc, loss_m, retry_m;
  bit   lost;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    run = 0; in_pll = 0; wait_cyc = 0; loss_m = 0; retry_m = 0; lost = 1'b0;
    foreach (pipe[i]) pipe[i] = 1'b0;
    sb.delete();
  endfunction

  // Lock run-length model: run counts consecutive qualified-high edges; FULL of them means released.
  function automatic void model_step();
    bit   ls;
    exp_t e;
    ls = pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = extlock;
    if (in_pll > 0) begin
      if (in_pll == PRC) begin in_pll = 0; wait_cyc = 0; end
      else in_pll++;
    end else if (lost) begin
      lost = 1'b0; run = 0; wait_cyc = 0;
    end else if (run >= FULL) begin
      if (!ls) begin
        lost = 1'b1; run = 0;
        if (loss_m < 255) loss_m++;
      end
    end else if (ls) begin
      run++;
    end else if (run > 0) begin
      run = 0; wait_cyc = 0;
    end else if (TMO_EN && wait_cyc == TMO - 1) begin
      in_pll = 1;
      if (retry_m < 255) retry_m++;
    end else begin
      wait_cyc++;
    end
    e.st    = (in_pll > 0) ? 5 : lost ? 4 : (run >= FULL) ? 3 : (run > STAB) ? 2 : (run > 0) ? 1 : 0;
    e.srn   = (e.st == 3) ? 1 : 0;
    e.rdy   = e.srn;
    e.pll   = (in_pll > 0) ? 1 : 0;
    e.loss  = loss_m;
    e.retry = retry_m;
    e.cyc   = edge_n;
    sb.push_back(e);
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (rst_n) model_step();
  end

  // Monitor: every registered output is compared one half-cycle after it updates.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("state_e%0d", e.cyc), state_o, e.st);
      chk($sformatf("sys_rst_n_e%0d", e.cyc), sys_rst_n_o, e.srn);
      chk($sformatf("ready_e%0d", e.cyc), ready_o, e.rdy);
      chk($sformatf("pll_rst_e%0d", e.cyc), pll_rst_o, e.pll);
      chk($sformatf("loss_cnt_e%0d", e.cyc), loss_cnt_o, e.loss);
      chk($sformatf("retry_cnt_e%0d", e.cyc), retry_cnt_o, e.retry);
    end
  end

  // Edges from now until the chosen output reaches tgt; sel 0 = sys_rst_n_o, 1 = pll_rst_o.
  task automatic measure(input string name, input int sel, input logic tgt, input int exp_n);
    int   n;
    logic v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = (sel == 0) ? sys_rst_n_o : pll_rst_o;
    end while (v !== tgt && n < 300);
    chk(name, n, exp_n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    extlock = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_sys_rst_n", sys_rst_n_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_pll_rst", pll_rst_o, 0);
    chk("rst_loss", loss_cnt_o, 0);
    chk("rst_retry", retry_cnt_o, 0);
    rst_n = 1'b1;

    // Clean start
    extlock = 1'b1;
    measure("release_clean", 0, 1'b1, 15);
    chk("ready_clean", ready_o, 1);
    repeat (5) @(negedge clk);

    // Loss in RUN and re-lock
    extlock = 1'b0;
    measure("loss_latency", 0, 1'b0, 3);
    chk("lost_state", state_o, 4);
    chk("loss_cnt_1", loss_cnt_o, 1);
    extlock = 1'b1;
    measure("release_relock", 0, 1'b1, 15);

    // Lock chatter from WAIT_LOCK
    extlock = 1'b0;
    repeat (10) @(negedge clk);
    extlock = 1'b1;
    repeat (6) @(negedge clk);
    extlock = 1'b0;
    repeat (3) @(negedge clk);
    extlock = 1'b1;
    measure("release_chatter", 0, 1'b1, 15);
    chk("loss_cnt_chatter", loss_cnt_o, 2);

    // Random lock behaviour
    repeat (150) begin
      extlock = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // Loss counter saturation
    repeat (260) begin
      extlock = 1'b1;
      repeat (16) @(negedge clk);
      extlock = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("loss_cnt_sat", loss_cnt_o, 255);

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    extlock = 1'b0;
    do_reset();
    measure("timeout_first", 1, 1'b1, 100);
    chk("retry_cnt_1", retry_cnt_o, 1);
    measure("pll_pulse_width", 1, 1'b0, 5);
    measure("timeout_repeat", 1, 1'b1, 100);
    repeat (256 * (TMO + PRC) + 10) @(negedge clk);
    chk("retry_cnt_sat", retry_cnt_o, 255);
    begin
      int n;
      n = 0;
      while (pll_rst_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("pll_pulse_found", pll_rst_o, 1);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pll_rst", pll_rst_o, 0);
    chk("async_sys_rst_n", sys_rst_n_o, 0);
    chk("async_loss", loss_cnt_o, 0);
    chk("async_retry", retry_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    extlock = 1'b0;
    repeat (1000) @(negedge clk);
    chk("no_timeout_state", state_o, 0);
    chk("no_timeout_pll", pll_rst_o, 0);
    extlock = 1'b1;
    repeat (20) @(negedge clk);
    chk("run_before_async", sys_rst_n_o, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_sys_rst_n", sys_rst_n_o, 0);
    chk("async_ready", ready_o, 0);
    chk("async_loss", loss_cnt_o, 0);
    chk("async_state", state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (30) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
